// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y counters with registered sync, blanking,
// marker and frame-count outputs, all decoded from the next-state position.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned FW       = 8,
  // Derived values; leave at their defaults.
  parameter int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  parameter int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  parameter int unsigned XW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  parameter int unsigned YW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          active_o,
  output logic          hblank_o,
  output logic          vblank_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          vblank_start_o,
  output logic [FW-1:0] frame_count_o
);

  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam logic [XW-1:0] XMax  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] YMax  = YW'(V_TOTAL - 1);

  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 || FW < 1) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] fc_q, fc_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic active_q, active_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic vblank_start_q, vblank_start_d;

  logic h_vis, v_vis, hs_on, vs_on;

  // Reset is folded into the next-state position so the flags decode (0,0) on that edge.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    fc_d = fc_q;
    if (!rst_n) begin
      x_d  = '0;
      y_d  = '0;
      fc_d = '0;
    end else if (ce_i) begin
      if (x_q == XMax) begin
        x_d = '0;
        if (y_q == YMax) begin
          y_d  = '0;
          fc_d = fc_q + FW'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    h_vis          = 32'(x_d) < H_ACTIVE;
    v_vis          = 32'(y_d) < V_ACTIVE;
    hs_on          = (32'(x_d) >= HsStart) && (32'(x_d) < HsEnd);
    vs_on          = (32'(y_d) >= VsStart) && (32'(y_d) < VsEnd);
    hsync_d        = hs_on ? HS_POL : ~HS_POL;
    vsync_d        = vs_on ? VS_POL : ~VS_POL;
    active_d       = h_vis && v_vis;
    hblank_d       = !h_vis;
    vblank_d       = !v_vis;
    line_start_d   = (x_d == '0);
    frame_start_d  = (x_d == '0) && (y_d == '0);
    vblank_start_d = (x_d == '0) && (32'(y_d) == V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    x_q            <= x_d;
    y_q            <= y_d;
    fc_q           <= fc_d;
    hsync_q        <= hsync_d;
    vsync_q        <= vsync_d;
    active_q       <= active_d;
    hblank_q       <= hblank_d;
    vblank_q       <= vblank_d;
    line_start_q   <= line_start_d;
    frame_start_q  <= frame_start_d;
    vblank_start_q <= vblank_start_d;
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign frame_count_o  = fc_q;
  assign hsync_o        = hsync_q;
  assign vsync_o        = vsync_q;
  assign active_o       = active_q;
  assign hblank_o       = hblank_q;
  assign vblank_o       = vblank_q;
  assign line_start_o   = line_start_q;
  assign frame_start_o  = frame_start_q;
  assign vblank_start_o = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes share clk/rst_n/ce; expected outputs come from the
// number of ce cycles since reset, plus hand-computed literal checkpoints.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  // Default mode
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic d_hs, d_vs, d_act, d_hb, d_vb, d_ls, d_fs, d_vbs;
  // Small mode, positive syncs, FW=2
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic [1:0] s_fc;
  logic s_hs, s_vs, s_act, s_hb, s_vb, s_ls, s_fs, s_vbs;
  // Short lines, default vertical timing
  logic [3:0] t_x;
  logic [9:0] t_y;
  logic [7:0] t_fc;
  logic t_hs, t_vs, t_act, t_hb, t_vb, t_ls, t_fs, t_vbs;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .x_o(d_x), .y_o(d_y), .hsync_o(d_hs), .vsync_o(d_vs),
    .active_o(d_act), .hblank_o(d_hb), .vblank_o(d_vb), .line_start_o(d_ls),
    .frame_start_o(d_fs), .vblank_start_o(d_vbs), .frame_count_o(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FW(2)
  ) u_sml (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .x_o(s_x), .y_o(s_y), .hsync_o(s_hs), .vsync_o(s_vs),
    .active_o(s_act), .hblank_o(s_hb), .vblank_o(s_vb), .line_start_o(s_ls),
    .frame_start_o(s_fs), .vblank_start_o(s_vbs), .frame_count_o(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1)
  ) u_tall (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .x_o(t_x), .y_o(t_y), .hsync_o(t_hs), .vsync_o(t_vs),
    .active_o(t_act), .hblank_o(t_hb), .vblank_o(t_vb), .line_start_o(t_ls),
    .frame_start_o(t_fs), .vblank_start_o(t_vbs), .frame_count_o(t_fc)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  longint n = 0;   // ce cycles since the last reset edge
  bit live = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      n    <= 0;
      live <= 1'b1;
    end else if (ce) begin
      n <= n + 1;
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (n=%0d)", nm, act, exp, n);
  endtask

  // Expected outputs follow directly from position = n mod frame, split into line/column.
  task automatic model_chk(
    input string nm,
    input int unsigned ha, hf, hs, hb, va, vf, vs, vb,
    input bit hp, vp,
    input int unsigned fw,
    input logic [63:0] ax, ay, afc,
    input logic ahs, avs, aact, ahb, avb, als, afs, avbs
  );
    longint ht = ha + hf + hs + hb;
    longint vt = va + vf + vs + vb;
    longint ex = n % ht;
    longint ey = (n / ht) % vt;
    longint ef = (n / (ht * vt)) % (longint'(1) << fw);
    cmp({nm, ".x"}, ax, ex);
    cmp({nm, ".y"}, ay, ey);
    cmp({nm, ".frame_count"}, afc, ef);
    cmp({nm, ".hsync"}, ahs, (ex >= ha + hf && ex < ha + hf + hs) ? hp : !hp);
    cmp({nm, ".vsync"}, avs, (ey >= va + vf && ey < va + vf + vs) ? vp : !vp);
    cmp({nm, ".active"}, aact, ex < ha && ey < va);
    cmp({nm, ".hblank"}, ahb, ex >= ha);
    cmp({nm, ".vblank"}, avb, ey >= va);
    cmp({nm, ".line_start"}, als, ex == 0);
    cmp({nm, ".frame_start"}, afs, ex == 0 && ey == 0);
    cmp({nm, ".vblank_start"}, avbs, ex == 0 && ey == va);
  endtask

  always @(negedge clk) begin
    if (live) begin
      model_chk("def", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8,
                d_x, d_y, d_fc, d_hs, d_vs, d_act, d_hb, d_vb, d_ls, d_fs, d_vbs);
      model_chk("sml", 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 2,
                s_x, s_y, s_fc, s_hs, s_vs, s_act, s_hb, s_vb, s_ls, s_fs, s_vbs);
      model_chk("tall", 8, 1, 2, 1, 480, 10, 2, 33, 1'b0, 1'b0, 8,
                t_x, t_y, t_fc, t_hs, t_vs, t_act, t_hb, t_vb, t_ls, t_fs, t_vbs);
    end
  end

  task automatic wait_n(input longint t);
    int k = 0;
    while (n != t && k < 20000) begin
      @(negedge clk);
      k++;
    end
    cmp("wait_n", n, t);
  endtask

  initial begin
    int t1, t2, rises;
    logic prev_ls;
    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    cmp("rst.x", d_x, 0);
    cmp("rst.y", d_y, 0);
    cmp("rst.active", d_act, 1);
    cmp("rst.hsync", d_hs, 1);
    cmp("rst.vsync", d_vs, 1);
    cmp("rst.frame_start", d_fs, 1);
    cmp("rst.vblank_start", d_vbs, 0);
    cmp("rst.sml_hsync", s_hs, 0);

    wait_n(1);   cmp("first_adv.x", d_x, 1);
    wait_n(8);   cmp("sml.x8_active", s_act, 0); cmp("sml.x8_hsync", s_hs, 0);
    wait_n(9);   cmp("sml.x9_hsync", s_hs, 1);
    wait_n(10);  cmp("sml.x10_hsync", s_hs, 1);
    wait_n(11);  cmp("sml.x11_hsync", s_hs, 0); cmp("sml.x11", s_x, 11);
    wait_n(12);  cmp("sml.wrap_x", s_x, 0); cmp("sml.wrap_y", s_y, 1);
    wait_n(84);  cmp("sml.frame_start", s_fs, 1); cmp("sml.fc1", s_fc, 1);
    wait_n(420); cmp("sml.fc_5frames", s_fc, 1);
    wait_n(655); cmp("def.hsync655", d_hs, 1);
    wait_n(656); cmp("def.hsync656", d_hs, 0);
    wait_n(751); cmp("def.hsync751", d_hs, 0);
    wait_n(752); cmp("def.hsync752", d_hs, 1);
    wait_n(799); cmp("def.x799", d_x, 799);
    wait_n(800); cmp("def.xwrap", d_x, 0); cmp("def.y1", d_y, 1);

    // Hold with ce=0 at x=300, then reset on a ce=0 edge
    wait_n(3500);
    ce = 1'b0;
    @(negedge clk);
    cmp("hold.x", d_x, 300);
    cmp("hold.y", d_y, 4);
    cmp("hold.sml_fc", s_fc, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ce    = 1'b1;
    cmp("midrst.x", d_x, 0);
    cmp("midrst.y", d_y, 0);
    cmp("midrst.frame_start", d_fs, 1);
    cmp("midrst.sml_fc", s_fc, 0);
    cmp("midrst.tall_y", t_y, 0);

    // Vertical timing on the short-line mode
    wait_n(5759); cmp("tall.act479", t_act, 0); cmp("tall.vb479", t_vb, 0);
    wait_n(5760);
    cmp("tall.y480", t_y, 480);
    cmp("tall.vbs480", t_vbs, 1);
    cmp("tall.vb480", t_vb, 1);
    cmp("tall.act480", t_act, 0);
    wait_n(5761); cmp("tall.vbs_x1", t_vbs, 0);
    wait_n(5879); cmp("tall.vs489", t_vs, 1);
    wait_n(5880); cmp("tall.vs490", t_vs, 0);
    wait_n(5903); cmp("tall.vs491", t_vs, 0);
    wait_n(5904); cmp("tall.vs492", t_vs, 1);
    wait_n(6299); cmp("tall.y524", t_y, 524);
    wait_n(6300); cmp("tall.frame_start", t_fs, 1); cmp("tall.fc", t_fc, 1);

    // ce toggling: line period of default mode in clk cycles
    rises   = 0;
    t1      = 0;
    t2      = 0;
    prev_ls = d_ls;
    for (int k = 0; k < 4000 && rises < 2; k++) begin
      ce = ~ce;
      @(negedge clk);
      if (d_ls && !prev_ls) begin
        if (rises == 0) t1 = cyc;
        else t2 = cyc;
        rises++;
      end
      prev_ls = d_ls;
    end
    cmp("ce_toggle.rises", rises, 2);
    if (rises == 2) cmp("ce_toggle.line_period", t2 - t1, 1600);

    ce = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
